// File: rtl/pkg_opengpu.sv
// Shared OpenGPU core types: warp geometry, per-warp context record and status codes.
package pkg_opengpu;

   localparam int WARPS_PER_CORE = 4;
   localparam int WARP_ID_WIDTH  = 2;
   localparam int DATA_WIDTH     = 32;
   localparam int WARP_SIZE      = 32;
   localparam int AGE_WIDTH      = 8;

   typedef enum logic [1:0] {
      WARP_IDLE    = 2'd0,
      WARP_READY   = 2'd1,
      WARP_STALLED = 2'd2,
      WARP_DONE    = 2'd3
   } warp_status_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc;
      logic [WARP_SIZE-1:0]  active_mask;
      warp_status_t          status;
      logic [AGE_WIDTH-1:0]  age;
      logic                  valid;
   } warp_context_t;

endpackage

// File: rtl/warp_scheduler_gto_pkg.sv
// Scheduler-local definitions: issue-slot FSM encoding and default greedy limit.
package warp_scheduler_gto_pkg;

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_HOLD  = 1'b1
   } sched_state_t;

   localparam int GTO_MAX_GREEDY = 4;

endpackage

// File: rtl/warp_scheduler_gto_if.sv
// Issue-slot valid/ready channel between the GTO scheduler and the fetch stage.
interface warp_scheduler_gto_if;
   import pkg_opengpu::*;

   logic                     issue_valid;
   logic                     issue_ready;
   logic [WARP_ID_WIDTH-1:0] issue_warp_id;
   logic [DATA_WIDTH-1:0]    issue_pc;
   logic [WARP_SIZE-1:0]     issue_mask;

   modport master (
      output issue_valid,
      output issue_warp_id,
      output issue_pc,
      output issue_mask,
      input  issue_ready
   );

   modport slave (
      input  issue_valid,
      input  issue_warp_id,
      input  issue_pc,
      input  issue_mask,
      output issue_ready
   );

endinterface

// File: rtl/warp_scheduler_gto_oldest.sv
// Combinational argmax over warp age restricted to an eligibility mask.
// Strict greater-than comparison in ascending id order makes the lowest id win ties.
module warp_oldest_select
   import pkg_opengpu::*;
#(
   parameter int NUM_WARPS = WARPS_PER_CORE
) (
   input  logic [NUM_WARPS-1:0]     elig,
   input  logic [AGE_WIDTH-1:0]     ages [NUM_WARPS],
   output logic                     sel_valid,
   output logic [WARP_ID_WIDTH-1:0] sel_id
);

   logic [AGE_WIDTH-1:0] best_age_s;

   // Linear scan keeping the first eligible warp with the largest age.
   always_comb begin
      sel_valid  = 1'b0;
      sel_id     = '0;
      best_age_s = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         if (elig[i] && (!sel_valid || (ages[i] > best_age_s))) begin
            sel_valid  = 1'b1;
            sel_id     = WARP_ID_WIDTH'(i);
            best_age_s = ages[i];
         end else begin
            best_age_s = best_age_s;
         end
      end
   end

endmodule

// File: rtl/warp_scheduler_gto.sv
// Greedy-then-oldest warp issue stage: one registered issue slot, in-flight
// tracking so an issued warp is not reselected until downstream releases it.
module warp_scheduler_gto
   import pkg_opengpu::*;
   import warp_scheduler_gto_pkg::*;
#(
   parameter int NUM_WARPS  = WARPS_PER_CORE,
   parameter int MAX_GREEDY = GTO_MAX_GREEDY
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  warp_context_t            contexts [NUM_WARPS],
   input  logic [NUM_WARPS-1:0]     sb_ready,
   warp_scheduler_gto_if.master     issue,
   output logic                     warp_issued,
   output logic [WARP_ID_WIDTH-1:0] issued_warp_id,
   input  logic                     release_valid,
   input  logic [WARP_ID_WIDTH-1:0] release_warp_id,
   input  logic                     flush,
   output logic [NUM_WARPS-1:0]     in_flight
);

   sched_state_t             state_r;
   logic                     issue_valid_r;
   logic [WARP_ID_WIDTH-1:0] issue_warp_id_r;
   logic [DATA_WIDTH-1:0]    issue_pc_r;
   logic [WARP_SIZE-1:0]     issue_mask_r;
   logic [NUM_WARPS-1:0]     in_flight_r;
   logic [WARP_ID_WIDTH-1:0] last_warp_r;
   logic [7:0]               greedy_cnt_r;

   logic [NUM_WARPS-1:0]     elig_s;
   logic [AGE_WIDTH-1:0]     ages_s [NUM_WARPS];
   logic                     old_valid_s;
   logic [WARP_ID_WIDTH-1:0] old_id_s;
   logic                     greedy_pick_s;
   logic                     pick_valid_s;
   logic [WARP_ID_WIDTH-1:0] pick_id_s;
   warp_context_t            pick_ctx_s;
   logic                     load_s;
   logic [NUM_WARPS-1:0]     in_flight_nxt_s;
   logic [7:0]               greedy_inc_s;

   // Per-warp eligibility and age vector for the oldest-first search.
   always_comb begin
      elig_s = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         ages_s[i] = contexts[i].age;
         elig_s[i] = contexts[i].valid
                   && (contexts[i].status == WARP_READY)
                   && (contexts[i].active_mask != '0)
                   && sb_ready[i]
                   && !in_flight_r[i];
      end
   end

   warp_oldest_select #(
      .NUM_WARPS (NUM_WARPS)
   ) u_oldest (
      .elig      (elig_s),
      .ages      (ages_s),
      .sel_valid (old_valid_s),
      .sel_id    (old_id_s)
   );

   // Greedy-versus-oldest arbitration and the slot load decision.
   always_comb begin
      greedy_pick_s = (greedy_cnt_r != 8'd0)
                    && elig_s[last_warp_r]
                    && (greedy_cnt_r < 8'(MAX_GREEDY));
      if (greedy_pick_s) begin
         pick_id_s = last_warp_r;
      end else begin
         pick_id_s = old_id_s;
      end
      pick_valid_s = greedy_pick_s | old_valid_s;
      pick_ctx_s   = contexts[pick_id_s];
      load_s       = enable & pick_valid_s & (~issue_valid_r | issue.issue_ready) & ~flush;
      if (greedy_cnt_r < 8'(MAX_GREEDY)) begin
         greedy_inc_s = greedy_cnt_r + 8'd1;
      end else begin
         greedy_inc_s = greedy_cnt_r;
      end
   end

   // Next in-flight vector: release and flush clear, a load sets last so set wins.
   always_comb begin
      in_flight_nxt_s = in_flight_r;
      if (release_valid) begin
         in_flight_nxt_s[release_warp_id] = 1'b0;
      end else begin
         in_flight_nxt_s = in_flight_nxt_s;
      end
      if (flush && issue_valid_r) begin
         in_flight_nxt_s[issue_warp_id_r] = 1'b0;
      end else begin
         in_flight_nxt_s = in_flight_nxt_s;
      end
      if (load_s) begin
         in_flight_nxt_s[pick_id_s] = 1'b1;
      end else begin
         in_flight_nxt_s = in_flight_nxt_s;
      end
   end

   // Issue-slot FSM with registered slot contents, greedy history and in-flight bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= S_EMPTY;
         issue_valid_r   <= 1'b0;
         issue_warp_id_r <= '0;
         issue_pc_r      <= '0;
         issue_mask_r    <= '0;
         in_flight_r     <= '0;
         last_warp_r     <= '0;
         greedy_cnt_r    <= 8'd0;
      end else begin
         in_flight_r <= in_flight_nxt_s;
         if (flush) begin
            greedy_cnt_r <= 8'd0;
         end else if (load_s) begin
            last_warp_r  <= pick_id_s;
            greedy_cnt_r <= greedy_pick_s ? greedy_inc_s : 8'd1;
         end
         case (state_r)
            S_EMPTY: begin
               if (load_s) begin
                  state_r         <= S_HOLD;
                  issue_valid_r   <= 1'b1;
                  issue_warp_id_r <= pick_id_s;
                  issue_pc_r      <= pick_ctx_s.pc;
                  issue_mask_r    <= pick_ctx_s.active_mask;
               end
            end
            S_HOLD: begin
               if (flush) begin
                  state_r       <= S_EMPTY;
                  issue_valid_r <= 1'b0;
               end else if (issue.issue_ready) begin
                  if (load_s) begin
                     issue_warp_id_r <= pick_id_s;
                     issue_pc_r      <= pick_ctx_s.pc;
                     issue_mask_r    <= pick_ctx_s.active_mask;
                  end else begin
                     state_r       <= S_EMPTY;
                     issue_valid_r <= 1'b0;
                  end
               end
            end
            default: begin
               state_r       <= S_EMPTY;
               issue_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign issue.issue_valid   = issue_valid_r;
   assign issue.issue_warp_id = issue_warp_id_r;
   assign issue.issue_pc      = issue_pc_r;
   assign issue.issue_mask    = issue_mask_r;
   assign warp_issued         = issue_valid_r & issue.issue_ready;
   assign issued_warp_id      = issue_warp_id_r;
   assign in_flight           = in_flight_r;

endmodule

// File: tb/tb_warp_scheduler_gto.sv
// Directed self-checking bench for the GTO warp scheduler (4 warps, greedy limit 4).
module tb_warp_scheduler_gto;
   import pkg_opengpu::*;
   import warp_scheduler_gto_pkg::*;

   logic                     clk;
   logic                     rst_n;
   logic                     enable;
   warp_context_t            contexts [4];
   logic [3:0]               sb_ready;
   logic                     warp_issued;
   logic [WARP_ID_WIDTH-1:0] issued_warp_id;
   logic                     release_valid;
   logic [WARP_ID_WIDTH-1:0] release_warp_id;
   logic                     flush;
   logic [3:0]               in_flight;
   int                       errors;
   int                       checks;

   warp_scheduler_gto_if iss ();

   warp_scheduler_gto #(
      .NUM_WARPS  (4),
      .MAX_GREEDY (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .enable          (enable),
      .contexts        (contexts),
      .sb_ready        (sb_ready),
      .issue           (iss),
      .warp_issued     (warp_issued),
      .issued_warp_id  (issued_warp_id),
      .release_valid   (release_valid),
      .release_warp_id (release_warp_id),
      .flush           (flush),
      .in_flight       (in_flight)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ctx(input int i, input warp_status_t st, input logic [7:0] age,
                          input logic [31:0] mask);
      contexts[i].valid       = 1'b1;
      contexts[i].status      = st;
      contexts[i].age         = age;
      contexts[i].pc          = 32'h100 + 32'(i) * 32'h110;
      contexts[i].active_mask = mask;
   endtask

   task automatic restart();
      rst_n           = 1'b0;
      enable          = 1'b1;
      sb_ready        = 4'b1111;
      iss.issue_ready = 1'b1;
      release_valid   = 1'b0;
      release_warp_id = 2'd0;
      flush           = 1'b0;
      for (int i = 0; i < 4; i++) contexts[i] = '0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      enable = 1'b0; sb_ready = 4'b0000; iss.issue_ready = 1'b0;
      release_valid = 1'b0; release_warp_id = 2'd0; flush = 1'b0;
      for (int i = 0; i < 4; i++) contexts[i] = '0;
      #3;
      checks++; if (iss.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", iss.issue_valid); end
      checks++; if (iss.issue_warp_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", iss.issue_warp_id); end
      checks++; if (iss.issue_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", iss.issue_pc); end
      checks++; if (iss.issue_mask !== 32'h0) begin errors++; $display("FAIL reset_mask got=%h exp=0", iss.issue_mask); end
      checks++; if (in_flight !== 4'b0000) begin errors++; $display("FAIL reset_inflight got=%b exp=0000", in_flight); end
      checks++; if (warp_issued !== 1'b0) begin errors++; $display("FAIL reset_issued got=%0b exp=0", warp_issued); end
   endtask

   task automatic test_oldest_tie();
      tick(); restart();
      set_ctx(0, WARP_READY, 8'd3, 32'hF);
      set_ctx(1, WARP_READY, 8'd7, 32'hF0);
      set_ctx(2, WARP_READY, 8'd7, 32'hF00);
      set_ctx(3, WARP_READY, 8'd1, 32'hF000);
      tick();
      checks++; if (iss.issue_valid !== 1'b1) begin errors++; $display("FAIL tie_valid got=%0b exp=1", iss.issue_valid); end
      checks++; if (iss.issue_warp_id !== 2'd1) begin errors++; $display("FAIL tie_id got=%0d exp=1", iss.issue_warp_id); end
      checks++; if (iss.issue_pc !== 32'h210) begin errors++; $display("FAIL tie_pc got=%h exp=210", iss.issue_pc); end
      checks++; if (iss.issue_mask !== 32'hF0) begin errors++; $display("FAIL tie_mask got=%h exp=f0", iss.issue_mask); end
      checks++; if (warp_issued !== 1'b1 || issued_warp_id !== 2'd1) begin errors++; $display("FAIL tie_pulse got=%0b/%0d exp=1/1", warp_issued, issued_warp_id); end
      checks++; if (in_flight !== 4'b0010) begin errors++; $display("FAIL tie_inflight got=%b exp=0010", in_flight); end
      tick();
      checks++; if (iss.issue_warp_id !== 2'd2) begin errors++; $display("FAIL b2b_id got=%0d exp=2", iss.issue_warp_id); end
   endtask

   task automatic test_greedy();
      tick(); restart();
      set_ctx(0, WARP_READY, 8'd2, 32'h1);
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (iss.issue_valid !== 1'b1 || iss.issue_warp_id !== 2'd0) begin errors++; $display("FAIL greedy_issue%0d got=%0b/%0d exp=1/0", k, iss.issue_valid, iss.issue_warp_id); end
         release_valid = 1'b1; release_warp_id = 2'd0;
         tick();
         release_valid = 1'b0;
         checks++; if (iss.issue_valid !== 1'b0 || in_flight !== 4'b0000) begin errors++; $display("FAIL greedy_gap%0d got=%0b/%b exp=0/0000", k, iss.issue_valid, in_flight); end
      end
      set_ctx(2, WARP_READY, 8'd5, 32'h4);
      tick();
      checks++; if (iss.issue_valid !== 1'b1 || iss.issue_warp_id !== 2'd2) begin errors++; $display("FAIL greedy_cap got=%0b/%0d exp=1/2", iss.issue_valid, iss.issue_warp_id); end
   endtask

   task automatic test_stall();
      tick(); restart();
      iss.issue_ready = 1'b0;
      set_ctx(2, WARP_READY, 8'd4, 32'h3);
      set_ctx(3, WARP_READY, 8'd1, 32'h7);
      tick();
      checks++; if (iss.issue_warp_id !== 2'd2 || iss.issue_pc !== 32'h320 || warp_issued !== 1'b0) begin errors++; $display("FAIL stall_load got=%0d/%h/%0b exp=2/320/0", iss.issue_warp_id, iss.issue_pc, warp_issued); end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (iss.issue_valid !== 1'b1 || iss.issue_warp_id !== 2'd2 || iss.issue_pc !== 32'h320 || warp_issued !== 1'b0 || in_flight !== 4'b0100) begin
            errors++; $display("FAIL stall_hold%0d got=%0b/%0d/%h/%0b/%b exp=1/2/320/0/0100", k, iss.issue_valid, iss.issue_warp_id, iss.issue_pc, warp_issued, in_flight);
         end
      end
      iss.issue_ready = 1'b1;
      #1;
      checks++; if (warp_issued !== 1'b1 || issued_warp_id !== 2'd2) begin errors++; $display("FAIL stall_pulse got=%0b/%0d exp=1/2", warp_issued, issued_warp_id); end
      tick();
      checks++; if (iss.issue_valid !== 1'b1 || iss.issue_warp_id !== 2'd3 || iss.issue_pc !== 32'h430) begin errors++; $display("FAIL stall_next got=%0b/%0d/%h exp=1/3/430", iss.issue_valid, iss.issue_warp_id, iss.issue_pc); end
   endtask

   task automatic test_scoreboard();
      tick(); restart();
      iss.issue_ready = 1'b0;
      sb_ready = 4'b1101;
      set_ctx(0, WARP_READY, 8'd2, 32'h1);
      set_ctx(1, WARP_READY, 8'd9, 32'h2);
      tick();
      checks++; if (iss.issue_warp_id !== 2'd0) begin errors++; $display("FAIL sb_skip got=%0d exp=0", iss.issue_warp_id); end
      sb_ready = 4'b1111;
      tick();
      checks++; if (iss.issue_warp_id !== 2'd0) begin errors++; $display("FAIL sb_held got=%0d exp=0", iss.issue_warp_id); end
      iss.issue_ready = 1'b1;
      tick();
      checks++; if (iss.issue_valid !== 1'b1 || iss.issue_warp_id !== 2'd1) begin errors++; $display("FAIL sb_release got=%0b/%0d exp=1/1", iss.issue_valid, iss.issue_warp_id); end
   endtask

   task automatic test_flush();
      tick(); restart();
      iss.issue_ready = 1'b0;
      set_ctx(3, WARP_READY, 8'd6, 32'h8);
      tick();
      checks++; if (iss.issue_valid !== 1'b1 || iss.issue_warp_id !== 2'd3 || in_flight !== 4'b1000) begin errors++; $display("FAIL flush_pre got=%0b/%0d/%b exp=1/3/1000", iss.issue_valid, iss.issue_warp_id, in_flight); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (iss.issue_valid !== 1'b0 || in_flight !== 4'b0000) begin errors++; $display("FAIL flush_clear got=%0b/%b exp=0/0000", iss.issue_valid, in_flight); end
      tick();
      checks++; if (iss.issue_valid !== 1'b1 || iss.issue_warp_id !== 2'd3) begin errors++; $display("FAIL flush_reload got=%0b/%0d exp=1/3", iss.issue_valid, iss.issue_warp_id); end
   endtask

   task automatic test_reset_mid();
      tick(); restart();
      set_ctx(0, WARP_READY, 8'd5, 32'h1);
      set_ctx(1, WARP_READY, 8'd4, 32'h2);
      set_ctx(3, WARP_READY, 8'd3, 32'h8);
      tick(); tick(); tick();
      checks++; if (iss.issue_valid !== 1'b1 || iss.issue_warp_id !== 2'd3 || in_flight !== 4'b1011) begin errors++; $display("FAIL mid_pre got=%0b/%0d/%b exp=1/3/1011", iss.issue_valid, iss.issue_warp_id, in_flight); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (iss.issue_valid !== 1'b0 || in_flight !== 4'b0000) begin errors++; $display("FAIL mid_reset got=%0b/%b exp=0/0000", iss.issue_valid, in_flight); end
      rst_n = 1'b1;
   endtask

   task automatic test_ineligible();
      tick(); restart();
      set_ctx(0, WARP_DONE,  8'd9, 32'h1);
      set_ctx(1, WARP_READY, 8'd8, 32'h0);
      set_ctx(2, WARP_READY, 8'd1, 32'h4);
      tick();
      checks++; if (iss.issue_valid !== 1'b1 || iss.issue_warp_id !== 2'd2) begin errors++; $display("FAIL inelig_pick got=%0b/%0d exp=1/2", iss.issue_valid, iss.issue_warp_id); end
      tick();
      checks++; if (iss.issue_valid !== 1'b0) begin errors++; $display("FAIL inelig_none got=%0b exp=0", iss.issue_valid); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_oldest_tie();
      test_greedy();
      test_stall();
      test_scoreboard();
      test_flush();
      test_reset_mid();
      test_ineligible();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/warp_scheduler_gto.md
Name: warp_scheduler_gto

Overview:
- Greedy-then-oldest (GTO) warp issue stage; consumes the per-warp context array from the warp context store and selects one warp per cycle for fetch.
- Outputs a registered valid/ready issue slot carrying warp id, PC and active mask.
- Returns the issue pulse (warp_issued / issued_warp_id) to the context store, which uses it for age update.
- Tracks in-flight warps so that a warp is not reissued before downstream releases it.

Parameters:
- NUM_WARPS, WARPS_PER_CORE: number of warp contexts scanned.
- MAX_GREEDY, 4: maximum consecutive selections of the same warp before forced oldest-first; range 1..255.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  when 0, no new selection; a held issue slot is kept
- contexts  in  warp_context_t[NUM_WARPS]  per-warp pc/active_mask/status/age/valid
- sb_ready  in  NUM_WARPS  per-warp scoreboard clear; 1 = no pending hazard
- issue_valid  out  1  issue slot occupied
- issue_ready  in  1  downstream accepts slot this cycle
- issue_warp_id  out  WARP_ID_WIDTH  selected warp
- issue_pc  out  DATA_WIDTH  PC captured at selection
- issue_mask  out  WARP_SIZE  active mask captured at selection
- warp_issued  out  1  = issue_valid & issue_ready (combinational)
- issued_warp_id  out  WARP_ID_WIDTH  = issue_warp_id
- release_valid  in  1  downstream finished with a warp; clear its in-flight bit
- release_warp_id  in  WARP_ID_WIDTH  warp to release
- flush  in  1  discard the held slot and clear its in-flight bit
- in_flight  out  NUM_WARPS  debug/visibility of in-flight bits

Behaviour:
- Reset values:
  - issue_valid = 0; issue_warp_id, issue_pc, issue_mask = 0.
  - in_flight = 0; last_warp = 0; greedy_cnt = 0; FSM = S_EMPTY.
  - warp_issued = 0 (it follows issue_valid).
- Eligibility of warp i, all conditions required:
  - contexts[i].valid
  - contexts[i].status == WARP_READY
  - contexts[i].active_mask != 0
  - sb_ready[i]
  - !in_flight[i]
- Selection, combinational, evaluated each cycle:
  - Greedy: if greedy_cnt != 0, last_warp is eligible and greedy_cnt < MAX_GREEDY, pick last_warp.
  - Oldest: otherwise pick the eligible warp with maximum age; on equal age, the lowest id wins.
  - No eligible warp: no pick.
- Load condition: enable & pick_valid & (!issue_valid | issue_ready) & !flush.
  - On load, the slot is set valid with id, pc and mask captured from contexts that cycle, and in_flight[pick] is set.
  - last_warp is updated to pick.
  - greedy_cnt becomes greedy_cnt+1 if the pick was greedy, else 1.
- FSM states:
  - S_EMPTY: issue_valid=0. A load goes to S_HOLD.
  - S_HOLD: issue_valid=1.
    - issue_ready with a load: stay in S_HOLD (back-to-back issue, 1 per cycle).
    - issue_ready without a load: go to S_EMPTY.
    - !issue_ready: stay, and the slot contents do not change.
- Latency: a warp that is eligible at cycle N is visible on issue_* at cycle N+1.
- In-flight release: release_valid clears in_flight[release_warp_id] at the next edge.
  - Release of a warp whose bit is already 0 has no effect.
  - A same-cycle set and release on the same id cannot occur, because set requires the bit to be 0. If it does occur, set wins.
- Flush:
  - Slot becomes invalid next cycle and in_flight[issue_warp_id] clears; no load happens that cycle.
  - warp_issued is still reported if issue_ready coincides with flush; downstream owns that case.
  - greedy_cnt resets to 0.
- Stall: while !issue_ready, issue_* are stable and no age-affecting pulse is produced.
- enable=0 blocks loads only; handshake, release and flush still operate.
- Wrap/saturation: greedy_cnt saturates at MAX_GREEDY. Ages are compared as unsigned 8-bit values.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); in-flight bits are lost and downstream is also reset.

Decomposition:
- Shared package pkg_opengpu provides: WARPS_PER_CORE, WARP_ID_WIDTH, DATA_WIDTH, WARP_SIZE, warp_context_t, warp_status_t.
- Add to the package: sched_state_t enum (S_EMPTY, S_HOLD) and the GTO_MAX_GREEDY default constant.
- One sub-module: warp_oldest_select.
  - Purely combinational argmax over age with an eligibility mask, lowest-id tie-break.
  - Outputs sel_valid and sel_id.

Test Plan:
- Four warps READY with ages 3,7,7,1, all sb_ready, issue_ready=1 -> warp 1 selected at cycle 1 (tie with warp 2, lowest id wins); warp_issued pulses with id 1; in_flight=4'b0010.
- Warp 0 only eligible, release each cycle after accept, MAX_GREEDY=4 -> warp 0 issued 4 times, then an oldest pick. If warp 2 is READY with age 5, warp 2 is issued 5th.
- issue_ready=0 for 3 cycles with warp 2 held -> issue_warp_id=2 and issue_pc stable; warp_issued=0 throughout; no other warp loads. Ready rises -> pulse for warp 2, next eligible warp appears the following cycle.
- sb_ready[1]=0 while warp 1 is oldest -> warp 1 skipped. sb_ready[1] set -> warp 1 chosen on the next free slot.
- flush while warp 3 is held -> issue_valid=0 next cycle; in_flight[3]=0; warp 3 reselectable the cycle after.
- rst_n asserted while issue_valid=1 and in_flight=4'b1011 -> issue_valid=0 and in_flight=0 immediately. A warp with status WARP_DONE or active_mask=0 is never selected.
